// File: rtl/inst_cache_resp_pkg.sv
// Shared definitions for the instruction-side cache responder.
//   - FSM state encoding (ICACHE_IDLE / ICACHE_REFILL)
//   - byte-offset width of a word fetch address
//   - common True/False, ZeroWord and RstEnable constants
package inst_cache_resp_pkg;

    typedef enum logic {
        ICACHE_IDLE   = 1'b0,
        ICACHE_REFILL = 1'b1
    } icache_state_e;

    localparam logic        True      = 1'b1;
    localparam logic        False     = 1'b0;
    localparam logic        RstEnable = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    // Fetches are whole 32-bit words, so pc[1:0] never selects anything.
    localparam int ByteOffW = 2;

endpackage

// File: rtl/inst_cache_resp_tag_array.sv
// icache_tag_array: valid + tag storage for the direct-mapped I-cache.
// Ports:
//   clk, rst        clock, async active-high reset (clears valid bits only)
//   rd_idx_i/tag_i  lookup index and tag; hit_o is combinational
//   wr_en_i         write tag and set valid for wr_idx_i
//   inv_all_i       clear every valid bit; wins over a same-cycle write
module icache_tag_array
    import inst_cache_resp_pkg::*;
#(
    parameter int LINES = 16,
    parameter int IDX_W = 4,
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx_i,
    input  logic [TAG_W-1:0] rd_tag_i,
    output logic             hit_o,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             inv_all_i
);

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_mem [LINES];

    always_comb begin
        valid_d = valid_q;
        if (inv_all_i) begin
            valid_d = '0;
        end else if (wr_en_i) begin
            valid_d[wr_idx_i] = True;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tags are not reset; a stale tag is harmless while its valid bit is 0.
    always_ff @(posedge clk) begin
        if (wr_en_i && !inv_all_i) begin
            tag_mem[wr_idx_i] <= wr_tag_i;
        end
    end

    assign hit_o = valid_q[rd_idx_i] && (tag_mem[rd_idx_i] == rd_tag_i);

endmodule

// File: rtl/inst_cache_resp.sv
// inst_cache_resp: fetch-stage instruction responder backed by a
// direct-mapped I-cache that refills one line from a word-wide memory bus.
// Ports:
//   clk, rst                 clock, async active-high reset
//   pc_i, req_i, flush_i     fetch address, fetch valid, invalidate all lines
//   inst_o, inst_valid_o     instruction word (zero-latency on a hit)
//   stall_req_o              hold PC/IR while the line is being fetched
//   mem_req_o, mem_addr_o    word read request, held until mem_ack_i
//   mem_rdata_i, mem_ack_i   read data with one-cycle acknowledge
//   hit_cnt_o, miss_cnt_o    saturating statistics, only with ICACHE_STATS_EN
// Optional feature macro: ICACHE_STATS_EN
module inst_cache_resp
    import inst_cache_resp_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              req_i,
    input  logic              flush_i,
    output logic [DATA_W-1:0] inst_o,
    output logic              inst_valid_o,
    output logic              stall_req_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(LINES);
    localparam int LINE_W = ADDR_W - OFF_W - ByteOffW;
    localparam int TAG_W  = LINE_W - IDX_W;

    icache_state_e     state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;   // refill line address (tag + index)

    logic [DATA_W-1:0] buf_q    [WORDS_PER_LINE];
    logic [DATA_W-1:0] data_mem [LINES][WORDS_PER_LINE];

    logic [OFF_W-1:0]  pc_off;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic              hit;
    logic              ack_acc;
    logic              last_ack;
    logic              fill_we;
    logic [1:0]        unused_byte_off;

    assign pc_off          = pc_i[ByteOffW +: OFF_W];
    assign pc_idx          = pc_i[ByteOffW + OFF_W +: IDX_W];
    assign pc_tag          = pc_i[ADDR_W-1 -: TAG_W];
    assign unused_byte_off = pc_i[1:0];

    // Acks outside REFILL are stray and must not move the counter.
    assign ack_acc  = (state_q == ICACHE_REFILL) && mem_ack_i;
    assign last_ack = ack_acc && (cnt_q == OFF_W'(WORDS_PER_LINE - 1));
    assign fill_we  = last_ack && !flush_i;

    icache_tag_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tags (
        .clk       (clk),
        .rst       (rst),
        .rd_idx_i  (pc_idx),
        .rd_tag_i  (pc_tag),
        .hit_o     (hit),
        .wr_en_i   (fill_we),
        .wr_idx_i  (line_q[IDX_W-1:0]),
        .wr_tag_i  (line_q[LINE_W-1 -: TAG_W]),
        .inv_all_i (flush_i)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        inst_o       = DATA_W'(ZeroWord);
        inst_valid_o = False;
        stall_req_o  = False;
        case (state_q)
            ICACHE_IDLE: begin
                if (req_i) begin
                    if (hit) begin
                        inst_o       = data_mem[pc_idx][pc_off];
                        inst_valid_o = True;
                    end else begin
                        stall_req_o = True;
                        line_d      = pc_i[ADDR_W-1 : ByteOffW + OFF_W];
                        state_d     = ICACHE_REFILL;
                    end
                end
            end
            ICACHE_REFILL: begin
                stall_req_o = True;
                if (flush_i) begin
                    state_d = ICACHE_IDLE;
                    cnt_d   = '0;
                end else if (mem_ack_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_ack) begin
                        state_d = ICACHE_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ICACHE_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q <= ICACHE_IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
        end
    end

    // Request/address come straight from state, so reset drops them at once.
    assign mem_req_o  = (state_q == ICACHE_REFILL);
    assign mem_addr_o = mem_req_o ? {line_q, cnt_q, {ByteOffW{1'b0}}} : '0;

    always_ff @(posedge clk) begin
        if (ack_acc) begin
            buf_q[cnt_q] <= mem_rdata_i;
        end
    end

    // The final word is taken from the bus directly; it is not yet buffered.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            for (int w = 0; w < WORDS_PER_LINE - 1; w++) begin
                data_mem[line_q[IDX_W-1:0]][w] <= buf_q[w];
            end
            data_mem[line_q[IDX_W-1:0]][WORDS_PER_LINE-1] <= mem_rdata_i;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if ((state_q == ICACHE_IDLE) && req_i && hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
        end
        if ((state_q == ICACHE_IDLE) && (state_d == ICACHE_REFILL)
            && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule
